// File: rtl/mult_pipeline_if.sv
// Operand/result bundle for mult_pipeline: the upstream source drives the
// operands and data_rdy (master); the multiplier returns result/result_rdy (slave).
interface mult_pipeline_if #(
    parameter int N = 8,
    parameter int M = 8
);
    logic             data_rdy;
    logic [N-1:0]     mult1;
    logic [M-1:0]     mult2;
    logic             result_rdy;
    logic [N+M-1:0]   result;

    modport master (
        output data_rdy, mult1, mult2,
        input  result_rdy, result
    );

    modport slave (
        input  data_rdy, mult1, mult2,
        output result_rdy, result
    );
endinterface

// File: rtl/mult_pipeline.sv
// Unsigned pipelined shift-and-add multiplier: M register stages, stage k adds
// mult1<<k when multiplier bit k is set; one product per clock, latency M edges.
module mult_pipeline #(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic          clk,
    input  logic          rstn,
    mult_pipeline_if.slave bus
);
    localparam int W = N + M;

    logic [M-1:0] valid_q;
    logic [W-1:0] acc_q    [M];
    logic [W-1:0] mcand_q  [M];
    logic [M-1:0] mplier_q [M];

    logic [M-1:0] valid_d;
    logic [W-1:0] acc_d    [M];
    logic [W-1:0] mcand_d  [M];
    logic [M-1:0] mplier_d [M];

    // Bubbles load all-zero data so an idle stage never carries stale operands.
    always_comb begin
        valid_d = '0;
        for (int unsigned k = 0; k < M; k++) begin
            acc_d[k]    = '0;
            mcand_d[k]  = '0;
            mplier_d[k] = '0;
        end

        if (bus.data_rdy) begin
            valid_d[0]  = 1'b1;
            mcand_d[0]  = {{M{1'b0}}, bus.mult1};
            mplier_d[0] = bus.mult2;
            acc_d[0]    = bus.mult2[0] ? {{M{1'b0}}, bus.mult1} : '0;
        end

        for (int unsigned k = 1; k < M; k++) begin
            if (valid_q[k-1]) begin
                valid_d[k]  = 1'b1;
                mcand_d[k]  = mcand_q[k-1] << 1;
                mplier_d[k] = mplier_q[k-1] >> 1;
                acc_d[k]    = acc_q[k-1] + (mplier_d[k][0] ? mcand_d[k] : '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < M; k++) begin
                acc_q[k]    <= '0;
                mcand_q[k]  <= '0;
                mplier_q[k] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign bus.result     = acc_q[M-1];
    assign bus.result_rdy = valid_q[M-1];
endmodule

// File: tb/tb_mult_pipeline.sv
// Bench for mult_pipeline: a product delay-queue reference checked every cycle,
// plus hand-computed expectations for the directed vectors.
module tb_mult_pipeline;
    localparam int N = 8;
    localparam int M = 8;
    localparam int W = N + M;
    localparam int LOGN = 4096;

    logic clk = 1'b0;
    logic rstn;

    mult_pipeline_if #(.N(N), .M(M)) bus ();

    mult_pipeline #(.N(N), .M(M)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference: each sampled pair becomes its product, then is delayed M-1 edges.
    logic         m_rdy  [M];
    logic [W-1:0] m_prod [M];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < M; i++) begin
                m_rdy[i]  <= 1'b0;
                m_prod[i] <= '0;
            end
        end else begin
            m_rdy[0]  <= bus.data_rdy;
            m_prod[0] <= bus.data_rdy ? W'(bus.mult1) * W'(bus.mult2) : '0;
            for (int i = 1; i < M; i++) begin
                m_rdy[i]  <= m_rdy[i-1];
                m_prod[i] <= m_prod[i-1];
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    logic [W-1:0] res_log [LOGN];
    logic         rdy_log [LOGN];

    int last_s;
    int s_stream [6];
    int s_ext    [4];
    int s_bub    [5];
    int s_mid    [4];
    int s_new;
    logic [W-1:0] pre_res, async_res;
    logic         pre_rdy, async_rdy;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic lit(input string name, input int idx, input logic exp_rdy, input logic [W-1:0] exp_res);
        check({name, ".rdy"}, 64'(rdy_log[idx]), 64'(exp_rdy));
        check({name, ".res"}, 64'(res_log[idx]), 64'(exp_res));
    endtask

    // Single checking process: per-cycle comparison, then the literal table at the end.
    always @(posedge clk) begin
        #2;
        if (cyc < LOGN) begin
            res_log[cyc] = bus.result;
            rdy_log[cyc] = bus.result_rdy;
        end
        check("cycle.result_rdy", 64'(bus.result_rdy), 64'(m_rdy[M-1]));
        check("cycle.result", 64'(bus.result), 64'(m_prod[M-1]));
        if (done) begin
            for (int i = 1; i <= 4; i++) lit("reset_hold", i, 1'b0, 16'd0);

            lit("stream0", s_stream[0] + M - 1, 1'b1, 16'd250);
            lit("stream1", s_stream[1] + M - 1, 1'b1, 16'd160);
            lit("stream2", s_stream[2] + M - 1, 1'b1, 16'd105);
            lit("stream3", s_stream[3] + M - 1, 1'b1, 16'd60);
            lit("stream4", s_stream[4] + M - 1, 1'b1, 16'd15);
            lit("stream5", s_stream[5] + M - 1, 1'b1, 16'd6);
            lit("stream_hold", s_stream[5] + M + 2, 1'b1, 16'd6);

            check("async.pre_rdy", 64'(pre_rdy), 64'd1);
            check("async.pre_res", 64'(pre_res), 64'd6);
            check("async.rdy", 64'(async_rdy), 64'd0);
            check("async.res", 64'(async_res), 64'd0);

            lit("ext_255x255", s_ext[0] + M - 1, 1'b1, 16'hFE01);
            lit("ext_0x200",   s_ext[1] + M - 1, 1'b1, 16'd0);
            lit("ext_200x0",   s_ext[2] + M - 1, 1'b1, 16'd0);
            lit("ext_1x255",   s_ext[3] + M - 1, 1'b1, 16'd255);

            lit("bub0", s_bub[0] + M - 1, 1'b1, 16'd63);
            lit("bub1", s_bub[1] + M - 1, 1'b0, 16'd0);
            lit("bub2", s_bub[2] + M - 1, 1'b1, 16'd144);
            lit("bub3", s_bub[3] + M - 1, 1'b1, 16'd255);
            lit("bub4", s_bub[4] + M - 1, 1'b0, 16'd0);

            for (int i = 0; i < 4; i++) lit("mid_flushed", s_mid[i] + M - 1, 1'b0, 16'd0);
            lit("mid_before_new", s_new + M - 2, 1'b0, 16'd0);
            lit("mid_new", s_new + M - 1, 1'b1, 16'd143);

            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    task automatic drive(input logic rdy, input logic [N-1:0] a, input logic [M-1:0] b);
        @(negedge clk);
        bus.data_rdy = rdy;
        bus.mult1    = a;
        bus.mult2    = b;
        last_s       = cyc + 1;
    endtask

    initial begin
        logic [N-1:0] sa [6];
        logic [M-1:0] sb [6];
        sa = '{8'd25, 8'd20, 8'd15, 8'd10, 8'd5, 8'd3};
        sb = '{8'd10, 8'd8, 8'd7, 8'd6, 8'd3, 8'd2};

        rstn         = 1'b0;
        bus.data_rdy = 1'b1;
        bus.mult1    = 8'd77;
        bus.mult2    = 8'd99;
        repeat (4) @(negedge clk);
        rstn         = 1'b1;
        bus.data_rdy = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            drive(1'b1, sa[i], sb[i]);
            s_stream[i] = last_s;
        end
        repeat (10) @(negedge clk);

        // Reset dropped mid-cycle; outputs must clear before any clock edge.
        @(negedge clk);
        pre_res   = bus.result;
        pre_rdy   = bus.result_rdy;
        rstn      = 1'b0;
        #1;
        async_res = bus.result;
        async_rdy = bus.result_rdy;
        @(negedge clk);
        rstn         = 1'b1;
        bus.data_rdy = 1'b0;

        drive(1'b1, 8'd255, 8'd255); s_ext[0] = last_s;
        drive(1'b1, 8'd0,   8'd200); s_ext[1] = last_s;
        drive(1'b1, 8'd200, 8'd0);   s_ext[2] = last_s;
        drive(1'b1, 8'd1,   8'd255); s_ext[3] = last_s;

        drive(1'b1, 8'd7,   8'd9);   s_bub[0] = last_s;
        drive(1'b0, 8'd99,  8'd88);  s_bub[1] = last_s;
        drive(1'b1, 8'd12,  8'd12);  s_bub[2] = last_s;
        drive(1'b1, 8'd255, 8'd1);   s_bub[3] = last_s;
        drive(1'b0, 8'd44,  8'd55);  s_bub[4] = last_s;
        repeat (M + 2) drive(1'b0, 8'd0, 8'd0);

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(i * 17 + 3), 8'(i * 29 + 5));
            s_mid[i] = last_s;
        end
        @(negedge clk);
        rstn         = 1'b0;
        bus.mult1    = 8'd66;
        bus.mult2    = 8'd77;
        @(negedge clk);
        rstn         = 1'b1;
        bus.data_rdy = 1'b0;
        drive(1'b1, 8'd11, 8'd13); s_new = last_s;
        repeat (M + 2) drive(1'b0, 8'd0, 8'd0);

        for (int i = 0; i < 1000; i++)
            drive(1'(($urandom_range(0, 3) != 0) ? 1 : 0), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        repeat (M + 2) drive(1'b0, 8'd0, 8'd0);

        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mult_pipeline.md
# mult_pipeline

Unsigned pipelined shift-and-add multiplier. It computes the product of an N-bit and an M-bit operand. It accepts a new operand pair on every clock cycle and returns each product a fixed number of cycles later with a valid flag. It is a streaming arithmetic datapath with no back-pressure; the upstream source marks valid inputs with `data_rdy`, and the downstream consumer samples `result` whenever `result_rdy` is high.

## Interface

Clocking: one clock. Reset is asynchronous and active-low.

Parameters:
- `N`, default 8: width of `mult1`, the multiplicand.
- `M`, default 8: width of `mult2`, the multiplier. It also sets the pipeline depth.

Ports:
- `clk`, input, 1 bit: rising-edge clock.
- `rstn`, input, 1 bit: reset, asynchronous assert, active-low.
- `data_rdy`, input, 1 bit: `mult1` and `mult2` are valid this cycle.
- `mult1`, input, N bits: unsigned multiplicand.
- `mult2`, input, M bits: unsigned multiplier.
- `result_rdy`, output, 1 bit: `result` holds a valid product.
- `result`, output, N+M bits: unsigned product `mult1*mult2`.

## Operation

- The pipeline has M register stages, numbered 0 to M-1. Stage k handles multiplier bit k. Each stage holds:
  - `valid`, 1 bit
  - accumulator, N+M bits
  - shifted multiplicand, N+M bits
  - remaining multiplier, M bits
- Stage 0 loads on a rising edge when `data_rdy`=1:
  - `valid` = 1
  - multiplicand = `mult1` zero-extended to N+M bits
  - accumulator = `mult2[0]` ? `mult1` : 0
  - remaining multiplier = `mult2`
- Stage k (k≥1) loads from stage k-1 on every rising edge:
  - multiplicand shifted left by 1
  - remaining multiplier shifted right by 1
  - accumulator += multiplicand(shifted) if the new remaining multiplier bit 0 is 1, so stage k adds `mult1<<k` when `mult2[k]`=1
  - `valid` is copied from stage k-1
- When a stage's incoming `valid`=0, it loads all-zero data and `valid`=0. Bubbles therefore carry zeros.
- `result` is the stage M-1 accumulator and `result_rdy` is the stage M-1 `valid`. Both are driven straight from registers.
- All arithmetic is unsigned. N+M bits cannot overflow: the maximum is (2^N-1)(2^M-1).
- There is no stall or back-pressure. A new pair is accepted every cycle `data_rdy`=1, and results leave in input order with no reordering.
- Constant inputs held with `data_rdy`=1 produce the same product every cycle.

## Timing

- Reset (`rstn`=0): all stage registers clear immediately, without waiting for a clock edge. `result`=0 and `result_rdy`=0 while `rstn` is low.
- Latency: operands sampled at rising edge t appear on `result`, with `result_rdy`=1, after rising edge t+M-1. That is M edges counting the sampling edge; for M=8, edge t+7.
- Throughput: one product per clock.
- The `result_rdy` pattern is the `data_rdy` pattern delayed by M-1 cycles. Bubbles are preserved exactly and show `result`=0.
- Reset mid-stream flushes every in-flight operation. After `rstn` rises, the first `result_rdy`=1 comes M-1 edges after the first sampled `data_rdy`=1.
- `data_rdy`, `mult1` and `mult2` must meet setup to the rising edge. Operands are ignored (treated as a bubble) when `data_rdy`=0.

## Test plan

- **Streamed pairs.** Release reset, then drive `data_rdy`=1 on consecutive cycles with the pairs (25,10), (20,8), (15,7), (10,6), (5,3), (3,2).
  - `result` must show 250, 160, 105, 60, 15, 6 on consecutive cycles, starting 7 edges after the first sampling edge, with `result_rdy`=1 throughout.
  - Because the inputs then hold (3,2), `result` stays at 6 afterwards.
- **Extremes.**
  - 255×255 gives 65025 (0xFE01).
  - 0×200 gives 0, and 200×0 gives 0, each with `result_rdy`=1.
  - 1×255 gives 255.
- **Bubbles.** Apply the `data_rdy` pattern 1,0,1,1,0 with pairs (7,9), x, (12,12), (255,1), x.
  - `result_rdy` must follow the pattern 1,0,1,1,0, delayed 7 cycles.
  - Results must be 63, 0, 144, 255, 0.
- **Reset state.** Hold `rstn`=0 with `data_rdy`=1 and active inputs.
  - `result`=0 and `result_rdy`=0 must hold for the whole reset.
  - The outputs must clear asynchronously, before the next clock edge.
- **Reset mid-stream.** Assert `rstn` for one cycle while 4 products are in flight.
  - None of those 4 may ever appear on the output.
  - The next valid result is the first pair sampled after `rstn` rises, 7 edges later.
- **Random regression.** Send 1000 random (`mult1`, `mult2`, `data_rdy`) triples.
  - Compare each output against a reference `mult1*mult2` pushed through a (M-1)-cycle delay queue.
  - `result_rdy` must match exactly on every cycle.
